// File: rtl/approx_pp_mult_seq_if.sv
// approx_pp_mult_seq_if: operand/product handshake bundle for the sequential partial-product multiplier
interface approx_pp_mult_seq_if #(
    parameter int W = 6
);
    localparam int RW = (W > 1) ? $clog2(W) : 1;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          approx;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] p;
    logic [RW-1:0] row_idx;
    modport master (
        output in_valid, a, b, approx, out_ready,
        input  in_ready, out_valid, p, row_idx
    );
    modport slave (
        input  in_valid, a, b, approx, out_ready,
        output in_ready, out_valid, p, row_idx
    );
endinterface

// File: rtl/approx_pp_mult_seq.sv
// approx_pp_mult_seq: one partial-product row per clock, optional truncation of the K low columns
module approx_pp_mult_seq #(
    parameter int W = 6,
    parameter int K = 3
) (
    input logic clk,
    input logic rst,
    approx_pp_mult_seq_if.slave bus
);
    localparam int RW = (W > 1) ? $clog2(W) : 1;
    localparam logic [2*W-1:0] LOW = {(2*W){1'b1}} >> (2*W - K);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [W-1:0] a_lat, b_lat;
    logic approx_lat;
    logic [2*W-1:0] acc, row, row_m;
    logic [RW-1:0] row_idx;
    logic last;
    assign last = row_idx == RW'(W - 1);
    assign row = {{W{1'b0}}, a_lat & {W{b_lat[row_idx]}}} << row_idx;
    assign row_m = approx_lat ? row & ~LOW : row;
    assign bus.in_ready = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.p = acc;
    assign bus.row_idx = row_idx;
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    // next state: accept in IDLE, leave RUN after the last row, release DONE on handshake
    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = bus.in_valid ? RUN : IDLE;
            RUN: state_n = last ? DONE : RUN;
            DONE: state_n = bus.out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end
    // operand latch and row accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            a_lat <= '0;
            b_lat <= '0;
            approx_lat <= 1'b0;
            acc <= '0;
            row_idx <= '0;
        end else if (state == IDLE && bus.in_valid) begin
            a_lat <= bus.a;
            b_lat <= bus.b;
            approx_lat <= bus.approx;
            acc <= '0;
            row_idx <= '0;
        end else if (state == RUN) begin
            acc <= acc + row_m;
            row_idx <= last ? '0 : row_idx + RW'(1);
        end
    end
endmodule

// File: tb/tb_approx_pp_mult_seq.sv
// tb_approx_pp_mult_seq: directed vectors plus handshake, reset and K=0 sweep sequences
module tb_approx_pp_mult_seq;
    localparam int W = 6;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    approx_pp_mult_seq_if #(.W(W)) bus ();
    approx_pp_mult_seq_if #(.W(W)) bus0 ();
    approx_pp_mult_seq #(.W(W), .K(3)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    approx_pp_mult_seq #(.W(W), .K(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic approx;
        logic [2*W-1:0] p;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_op(input bit sel, input logic [W-1:0] a, input logic [W-1:0] b, input logic ap,
                          output logic [2*W-1:0] p, output int lat);
        int n = 0;
        while (!(sel ? bus0.in_ready : bus.in_ready) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (sel) begin
            bus0.a = a; bus0.b = b; bus0.approx = ap; bus0.in_valid = 1'b1;
        end else begin
            bus.a = a; bus.b = b; bus.approx = ap; bus.in_valid = 1'b1;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus0.in_valid = 1'b0;
        bus.a = ~a; bus.b = ~b; bus.approx = ~ap;
        bus0.a = ~a; bus0.b = ~b; bus0.approx = ~ap;
        lat = 0;
        while (!(sel ? bus0.out_valid : bus.out_valid) && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        p = sel ? bus0.p : bus.p;
    endtask

    task automatic handshake(input bit sel);
        if (sel) bus0.out_ready = 1'b1; else bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0; bus0.out_ready = 1'b0;
    endtask

    initial begin
        logic [2*W-1:0] p, p_seen;
        int lat, bad, episodes;
        logic prev;
        vecs[0] = '{6'd1, 6'd3, 1'b0, 12'd3};
        vecs[1] = '{6'd63, 6'd63, 1'b0, 12'd3969};
        vecs[2] = '{6'd1, 6'd3, 1'b1, 12'd0};
        vecs[3] = '{6'd63, 6'd63, 1'b1, 12'd3952};
        vecs[4] = '{6'd0, 6'd63, 1'b0, 12'd0};
        vecs[5] = '{6'd5, 6'd7, 1'b0, 12'd35};
        vecs[6] = '{6'd5, 6'd7, 1'b1, 12'd24};
        vecs[7] = '{6'd63, 6'd1, 1'b1, 12'd56};
        vecs[8] = '{6'd42, 6'd21, 1'b0, 12'd882};
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.approx = 1'b0; bus.out_ready = 1'b0;
        bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.approx = 1'b0; bus0.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_p", 64'(bus.p), 64'd0);
        check("rst_row_idx", 64'(bus.row_idx), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) begin
            run_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].approx, p, lat);
            check($sformatf("vec%0d_p", i), 64'(p), 64'(vecs[i].p));
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(W));
            handshake(1'b0);
        end
        run_op(1'b0, 6'd63, 6'd63, 1'b0, p, lat);
        check("bp_p", 64'(p), 64'd3969);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.p !== 12'd3969 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad++;
        end
        check("bp_hold", 64'(bad), 64'd0);
        handshake(1'b0);
        check("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
        check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
        bus.a = 6'd9; bus.b = 6'd11; bus.approx = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0;
        repeat (2) @(posedge clk);
        #1;
        bus.a = 6'd5; bus.b = 6'd5; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        episodes = 0; prev = 1'b0; p_seen = '0;
        for (int i = 0; i < 30; i++) begin
            if (bus.out_valid && !prev) begin
                episodes++;
                p_seen = bus.p;
            end
            prev = bus.out_valid;
            bus.out_ready = bus.out_valid;
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
        check("ignore_episodes", 64'(episodes), 64'd1);
        check("ignore_p", 64'(p_seen), 64'd99);
        bus.a = 6'd63; bus.b = 6'd63; bus.approx = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_row_idx", 64'(bus.row_idx), 64'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_p", 64'(bus.p), 64'd0);
        check("midrst_row_idx0", 64'(bus.row_idx), 64'd0);
        run_op(1'b0, 6'd2, 6'd7, 1'b0, p, lat);
        check("after_rst_p", 64'(p), 64'd14);
        check("after_rst_lat", 64'(lat), 64'(W));
        handshake(1'b0);
        for (int x = 0; x < 64; x++) begin
            for (int y = 0; y < 64; y++) begin
                run_op(1'b1, 6'(x), 6'(y), 1'b1, p, lat);
                check($sformatf("k0_%0dx%0d", x, y), 64'(p), 64'(x * y));
                handshake(1'b1);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
